// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e  : sequencer states (normal run, load-use bubble, interrupt pending/taken)
//   PCSEL_*  : encodings of the PC mux select driven by the controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      IRQ_PEND = 2'd2,
      IRQ_TAKE = 2'd3
   } state_e;

   localparam logic [1:0] PCSEL_PC4 = 2'b00;
   localparam logic [1:0] PCSEL_BR  = 2'b01;
   localparam logic [1:0] PCSEL_JMP = 2'b10;
   localparam logic [1:0] PCSEL_IRQ = 2'b11;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
//   id_rs_i, id_rt_i : source registers of the instruction in ID
//   id_uses_rt_i     : ID instruction actually reads Rt
//   ex_mem_read_i    : instruction in EX is a load
//   ex_rt_i          : destination register of that load
//   lu_o             : ID consumes a value the load has not produced yet
module load_use_detect (
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_uses_rt_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rt_i,
   output logic       lu_o
);

   // r0 is hard-wired to zero, so a load into it never creates a dependency.
   always_comb begin
      lu_o = ex_mem_read_i && (ex_rt_i != 5'd0) &&
             ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/PC-select sequencer for the 5-stage pipeline.
//   clk, reset_b              : clock, asynchronous active-low reset
//   ID_Rs/ID_Rt/ID_UsesRt     : operands of the instruction in ID
//   ID_Jump                   : ID holds j/jal/jr
//   ID_EX_MemRead/ID_EX_Rt    : load in EX and its destination
//   PCSrcB                    : branch taken (resolved in EX)
//   MemBusy                   : data memory not ready, freeze pipeline
//   IrqReq/IrqEn              : level interrupt request / global enable
//   StatClr                   : synchronous clear of StallCycles
//   PCWrite/IF_ID_Write       : PC and IF/ID enables
//   IF_ID_Flush/ID_EX_Flush   : turn IF/ID into nop / ID/EX into bubble
//   PipeHold                  : hold ID/EX and EX/MEM
//   PCSel                     : PC mux select (PCSEL_*)
//   IrqAck/EpcWrite           : one-cycle pulses when an interrupt is taken
//   StallCycles               : saturating count of cycles with PCWrite=0
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned IRQ_GAP = 4
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRt,
   input  logic             ID_Jump,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_Rt,
   input  logic             PCSrcB,
   input  logic             MemBusy,
   input  logic             IrqReq,
   input  logic             IrqEn,
   input  logic             StatClr,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             PipeHold,
   output logic [1:0]       PCSel,
   output logic             IrqAck,
   output logic             EpcWrite,
   output logic [CNT_W-1:0] StallCycles
);

   localparam int unsigned GAP_W = $clog2(IRQ_GAP + 1);

   state_e           state_q, state_d;
   logic             run_en_q;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             lu;
   logic             lu_eff;
   logic             take_fire;

   load_use_detect u_lu (
      .id_rs_i       (ID_Rs),
      .id_rt_i       (ID_Rt),
      .id_uses_rt_i  (ID_UsesRt),
      .ex_mem_read_i (ID_EX_MemRead),
      .ex_rt_i       (ID_EX_Rt),
      .lu_o          (lu)
   );

   // The load that caused a bubble is still visible for one more cycle;
   // ignoring it in LU_STALL keeps the stall to exactly one bubble.
   assign lu_eff = lu && (state_q != LU_STALL);

   // An interrupt is only committed when neither memory nor a branch preempts it.
   assign take_fire = run_en_q && !MemBusy && !PCSrcB && (state_q == IRQ_TAKE);

   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      PipeHold    = 1'b0;
      PCSel       = PCSEL_PC4;
      IrqAck      = 1'b0;
      EpcWrite    = 1'b0;

      if (!run_en_q) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
      end else if (MemBusy) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         PipeHold    = 1'b1;
      end else begin
         if (PCSrcB) begin
            PCSel       = PCSEL_BR;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end else if (state_q == IRQ_TAKE) begin
            PCSel       = PCSEL_IRQ;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            IrqAck      = 1'b1;
            EpcWrite    = 1'b1;
         end else if (lu_eff) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end else if (ID_Jump) begin
            PCSel       = PCSEL_JMP;
            IF_ID_Flush = 1'b1;
         end

         case (state_q)
            RUN: begin
               // Accepting a request takes precedence over recording the bubble;
               // any remaining load-use is still stalled while pending.
               if (IrqReq && IrqEn && (gap_q == '0)) begin
                  state_d = IRQ_PEND;
               end else if (lu && !PCSrcB) begin
                  state_d = LU_STALL;
               end
            end
            LU_STALL: state_d = RUN;
            IRQ_PEND: begin
               if (!IrqEn) begin
                  state_d = RUN;
               end else if (!(PCSrcB || lu || ID_Jump)) begin
                  state_d = IRQ_TAKE;
               end
            end
            IRQ_TAKE: state_d = PCSrcB ? IRQ_PEND : RUN;
            default:  state_d = RUN;
         endcase
      end
   end

   always_comb begin
      gap_d = gap_q;
      if (run_en_q && !MemBusy) begin
         if (take_fire) begin
            gap_d = GAP_W'(IRQ_GAP);
         end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (StatClr) begin
         stall_d = '0;
      end else if (run_en_q && !PCWrite && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q  <= RUN;
         run_en_q <= 1'b0;
         gap_q    <= '0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         run_en_q <= 1'b1;
         gap_q    <= gap_d;
         stall_q  <= stall_d;
      end
   end

   assign StallCycles = stall_q;

endmodule
